// File: rtl/writeback_stage_if.sv
// Memory-to-writeback bus: one retiring instruction's status, destinations and results.
interface writeback_stage_if;
  logic [3:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE;
  logic [63:0] m_valM;
  logic [3:0]  m_destE;
  logic [3:0]  m_destM;

  modport master (output m_stat, m_icode, m_valE, m_valM, m_destE, m_destM);
  modport slave  (input  m_stat, m_icode, m_valE, m_valM, m_destE, m_destM);
endinterface

// File: rtl/writeback_stage.sv
// Y86-64 W stage: W pipeline register, register-file commit and read ports,
// sticky halt on non-AOK status, and retired-instruction counter.
module writeback_stage #(
  parameter logic [3:0]  RNONE = 4'hF,
  parameter int unsigned NREG  = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  W_stall,
  input  logic                  W_bubble,
  writeback_stage_if.slave      m_if,
  input  logic [3:0]            srcA,
  input  logic [3:0]            srcB,
  output logic [63:0]           rvalA,
  output logic [63:0]           rvalB,
  output logic [3:0]            W_stat,
  output logic [3:0]            W_icode,
  output logic [3:0]            W_destE,
  output logic [3:0]            W_destM,
  output logic [63:0]           W_valE,
  output logic [63:0]           W_valM,
  output logic [3:0]            stat,
  output logic                  halted,
  output logic [63:0]           retired
);

  localparam int unsigned DW   = 64;
  localparam int unsigned RW   = 4;
  localparam logic [3:0]  SAOK = 4'h1;
  localparam logic [3:0]  INOP = 4'h1;

  logic [RW-1:0] w_stat_q,  w_stat_d;
  logic [RW-1:0] w_icode_q, w_icode_d;
  logic [RW-1:0] w_destE_q, w_destE_d;
  logic [RW-1:0] w_destM_q, w_destM_d;
  logic [DW-1:0] w_valE_q,  w_valE_d;
  logic [DW-1:0] w_valM_q,  w_valM_d;
  logic          halted_q,  halted_d;
  logic [DW-1:0] retired_q, retired_d;
  logic [DW-1:0] regs_q [NREG];
  logic          commit_c;

  // Next-state for W register, halt flag and retire counter.
  // A non-AOK instruction freezes W so its status stays architecturally visible.
  always_comb begin
    w_stat_d  = w_stat_q;
    w_icode_d = w_icode_q;
    w_destE_d = w_destE_q;
    w_destM_d = w_destM_q;
    w_valE_d  = w_valE_q;
    w_valM_d  = w_valM_q;
    halted_d  = halted_q;
    retired_d = retired_q;
    commit_c  = !halted_q && !W_stall && (w_stat_q == SAOK);

    if (!halted_q) begin
      if (w_stat_q != SAOK) begin
        halted_d = 1'b1;
      end else if (!W_stall) begin
        if (W_bubble) begin
          w_stat_d  = SAOK;
          w_icode_d = INOP;
          w_destE_d = RNONE;
          w_destM_d = RNONE;
          w_valE_d  = '0;
          w_valM_d  = '0;
        end else begin
          w_stat_d  = m_if.m_stat;
          w_icode_d = m_if.m_icode;
          w_destE_d = m_if.m_destE;
          w_destM_d = m_if.m_destM;
          w_valE_d  = m_if.m_valE;
          w_valM_d  = m_if.m_valM;
        end
      end
    end

    if (commit_c && (w_icode_q != INOP)) begin
      retired_d = retired_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_stat_q  <= SAOK;
      w_icode_q <= INOP;
      w_destE_q <= RNONE;
      w_destM_q <= RNONE;
      w_valE_q  <= '0;
      w_valM_q  <= '0;
      halted_q  <= 1'b0;
      retired_q <= '0;
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      w_stat_q  <= w_stat_d;
      w_icode_q <= w_icode_d;
      w_destE_q <= w_destE_d;
      w_destM_q <= w_destM_d;
      w_valE_q  <= w_valE_d;
      w_valM_q  <= w_valM_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
      // M write is issued last so it wins when both ports target one register.
      if (commit_c && (w_destE_q != RNONE)) regs_q[w_destE_q] <= w_valE_q;
      if (commit_c && (w_destM_q != RNONE)) regs_q[w_destM_q] <= w_valM_q;
    end
  end

  assign rvalA   = (srcA == RNONE) ? '0 : regs_q[srcA];
  assign rvalB   = (srcB == RNONE) ? '0 : regs_q[srcB];
  assign W_stat  = w_stat_q;
  assign W_icode = w_icode_q;
  assign W_destE = w_destE_q;
  assign W_destM = w_destM_q;
  assign W_valE  = w_valE_q;
  assign W_valM  = w_valM_q;
  assign stat    = w_stat_q;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: reset, commits, stall/bubble, halt and recovery.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        W_stall, W_bubble;
  logic [3:0]  srcA, srcB;
  logic [63:0] rvalA, rvalB;
  logic [3:0]  W_stat, W_icode, W_destE, W_destM, stat;
  logic [63:0] W_valE, W_valM, retired;
  logic        halted;
  int          n_vec = 0;
  int          n_err = 0;

  writeback_stage_if mif ();

  writeback_stage dut (
    .clk(clk), .reset(reset), .W_stall(W_stall), .W_bubble(W_bubble), .m_if(mif),
    .srcA(srcA), .srcB(srcB), .rvalA(rvalA), .rvalB(rvalB),
    .W_stat(W_stat), .W_icode(W_icode), .W_destE(W_destE), .W_destM(W_destM),
    .W_valE(W_valE), .W_valM(W_valM), .stat(stat), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] st, input logic [3:0] ic, input logic [3:0] de,
                       input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
    mif.m_stat = st; mif.m_icode = ic; mif.m_destE = de;
    mif.m_valE = ve; mif.m_destM = dm; mif.m_valM = vm;
  endtask

  task automatic test_reset();
    drive(4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom},
          4'($urandom), {$urandom, $urandom});
    W_stall = 1'($urandom); W_bubble = 1'($urandom);
    reset = 1'b1;
    step();
    reset = 1'b0; W_stall = 1'b0; W_bubble = 1'b0;
    drive(4'h1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    n_vec++;
    if (W_icode !== 4'h1 || W_destE !== 4'hF || W_destM !== 4'hF || stat !== 4'h1 ||
        W_valE !== 64'h0 || W_valM !== 64'h0)
      begin n_err++; $display("FAIL reset_wreg got icode=%h dE=%h dM=%h stat=%h vE=%h vM=%h want 1 f f 1 0 0",
                              W_icode, W_destE, W_destM, stat, W_valE, W_valM); end
    n_vec++;
    if (halted !== 1'b0 || retired !== 64'h0)
      begin n_err++; $display("FAIL reset_ctl got halted=%b retired=%0d want 0 0", halted, retired); end
    for (int i = 0; i < 16; i++) begin
      srcA = 4'(i);
      #1;
      n_vec++;
      if (rvalA !== 64'h0)
        begin n_err++; $display("FAIL reset_reg%0d got %h want 0", i, rvalA); end
    end
  endtask

  task automatic test_irmovq();
    drive(4'h1, 4'h3, 4'h2, 64'h1234, 4'hF, 64'h0);
    step();
    drive(4'h1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    srcA = 4'h2; srcB = 4'h2;
    #1;
    n_vec++;
    if (W_valE !== 64'h1234 || W_destE !== 4'h2 || rvalA !== 64'h0 || retired !== 64'd0)
      begin n_err++; $display("FAIL irmovq_edge1 got vE=%h dE=%h rvalA=%h ret=%0d want 1234 2 0 0",
                              W_valE, W_destE, rvalA, retired); end
    step();
    n_vec++;
    if (rvalA !== 64'h1234 || rvalB !== 64'h1234 || retired !== 64'd1)
      begin n_err++; $display("FAIL irmovq_edge2 got rvalA=%h rvalB=%h ret=%0d want 1234 1234 1",
                              rvalA, rvalB, retired); end
    step();
    n_vec++;
    if (retired !== 64'd1)
      begin n_err++; $display("FAIL irmovq_nopcount got ret=%0d want 1", retired); end
  endtask

  task automatic test_popq();
    drive(4'h1, 4'hB, 4'h4, 64'h100, 4'h4, 64'hBEEF);
    step();
    drive(4'h1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    srcA = 4'h4;
    #1;
    n_vec++;
    if (rvalA !== 64'hBEEF || retired !== 64'd2)
      begin n_err++; $display("FAIL popq_rsp got reg4=%h ret=%0d want beef 2", rvalA, retired); end
  endtask

  task automatic test_stall_bubble();
    drive(4'h1, 4'h6, 4'h3, 64'h7, 4'hF, 64'h0);
    step();
    drive(4'h1, 4'h3, 4'h5, 64'h99, 4'hF, 64'h0);
    W_stall = 1'b1; W_bubble = 1'b1; srcA = 4'h3;
    for (int c = 0; c < 3; c++) begin
      step();
      n_vec++;
      if (W_destE !== 4'h3 || W_valE !== 64'h7 || W_icode !== 4'h6 || rvalA !== 64'h0 || retired !== 64'd2)
        begin n_err++; $display("FAIL stall_hold%0d got dE=%h vE=%h ic=%h reg3=%h ret=%0d want 3 7 6 0 2",
                                c, W_destE, W_valE, W_icode, rvalA, retired); end
    end
    W_stall = 1'b0;
    step();
    W_bubble = 1'b0;
    drive(4'h1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    n_vec++;
    if (W_icode !== 4'h1 || W_destE !== 4'hF || W_valE !== 64'h0)
      begin n_err++; $display("FAIL bubble_load got ic=%h dE=%h vE=%h want 1 f 0", W_icode, W_destE, W_valE); end
    n_vec++;
    if (rvalA !== 64'h7 || retired !== 64'd3)
      begin n_err++; $display("FAIL bubble_commit got reg3=%h ret=%0d want 7 3", rvalA, retired); end
  endtask

  task automatic test_back_to_back();
    drive(4'h1, 4'h3, 4'h6, 64'hA, 4'hF, 64'h0);
    step();
    drive(4'h1, 4'h6, 4'h6, 64'hB, 4'h8, 64'hC);
    step();
    drive(4'h1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    srcA = 4'h6; srcB = 4'h8;
    #1;
    n_vec++;
    if (rvalA !== 64'hA || rvalB !== 64'h0 || W_destM !== 4'h8)
      begin n_err++; $display("FAIL b2b_first got reg6=%h reg8=%h dM=%h want a 0 8", rvalA, rvalB, W_destM); end
    step();
    n_vec++;
    if (rvalA !== 64'hB || rvalB !== 64'hC || retired !== 64'd5)
      begin n_err++; $display("FAIL b2b_second got reg6=%h reg8=%h ret=%0d want b c 5", rvalA, rvalB, retired); end
  endtask

  task automatic test_halt();
    drive(4'h2, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    drive(4'h1, 4'h3, 4'h5, 64'h55, 4'hF, 64'h0);
    n_vec++;
    if (W_stat !== 4'h2 || halted !== 1'b0)
      begin n_err++; $display("FAIL halt_inW got stat=%h halted=%b want 2 0", W_stat, halted); end
    step();
    n_vec++;
    if (halted !== 1'b1 || stat !== 4'h2 || retired !== 64'd5)
      begin n_err++; $display("FAIL halt_rise got halted=%b stat=%h ret=%0d want 1 2 5", halted, stat, retired); end
    srcA = 4'h5;
    for (int c = 0; c < 3; c++) begin
      drive(4'h1, 4'h3, 4'h5, 64'h55 + 64'(c), 4'hF, 64'h0);
      step();
    end
    n_vec++;
    if (halted !== 1'b1 || stat !== 4'h2 || W_icode !== 4'h0 || rvalA !== 64'h0 || retired !== 64'd5)
      begin n_err++; $display("FAIL halt_frozen got halted=%b stat=%h ic=%h reg5=%h ret=%0d want 1 2 0 0 5",
                              halted, stat, W_icode, rvalA, retired); end
  endtask

  task automatic test_reset_mid_halt();
    reset = 1'b1;
    step();
    reset = 1'b0;
    srcA = 4'h4;
    #1;
    n_vec++;
    if (halted !== 1'b0 || retired !== 64'd0 || stat !== 4'h1 || rvalA !== 64'h0)
      begin n_err++; $display("FAIL rst_halt got halted=%b ret=%0d stat=%h reg4=%h want 0 0 1 0",
                              halted, retired, stat, rvalA); end
    drive(4'h1, 4'h3, 4'h1, 64'h9, 4'hF, 64'h0);
    step();
    drive(4'h1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    srcA = 4'h1;
    #1;
    n_vec++;
    if (rvalA !== 64'h9 || retired !== 64'd1 || halted !== 1'b0)
      begin n_err++; $display("FAIL rst_resume got reg1=%h ret=%0d halted=%b want 9 1 0", rvalA, retired, halted); end
  endtask

  initial begin
    reset = 1'b1; W_stall = 1'b0; W_bubble = 1'b0; srcA = 4'h0; srcB = 4'h0;
    drive(4'h1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    test_reset();
    test_irmovq();
    test_popq();
    test_stall_bubble();
    test_back_to_back();
    test_halt();
    test_reset_mid_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final (W) stage of the pipelined Y86-64 processor. Latches the memory stage's outputs into the W pipeline register and commits `valE`/`valM` to the 15-entry register file. Provides the decode stage's register-file read ports, and W-register values for decode forwarding. Tracks architectural status, freezes the machine on halt or exception, and counts retired instructions.

## Interface
Parameters
- `RNONE`, 4'hF: register ID meaning "no register"
- `NREG`, 15: architectural registers (%rax..%r14, IDs 0-14)

Ports (clk and reset first)
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `W_stall`  in  1  hold W register (from pipeline control)
- `W_bubble`  in  1  load bubble into W register
- `m_stat`  in  4  status from memory stage: AOK=1, HLT=2, ADR=3, INS=4
- `m_icode`  in  4  icode from memory stage
- `m_valE`  in  64  ALU result passed through memory stage
- `m_valM`  in  64  data read by memory stage
- `m_destE`  in  4  E-port destination register
- `m_destM`  in  4  M-port destination register
- `srcA`, `srcB`  in  4 each  decode read addresses
- `rvalA`, `rvalB`  out  64 each  register-file read data
- `W_stat`, `W_icode`, `W_destE`, `W_destM`  out  4 each  W register contents (forwarding)
- `W_valE`, `W_valM`  out  64 each  W register contents (forwarding)
- `stat`  out  4  architectural status (= `W_stat`)
- `halted`  out  1  sticky; machine frozen
- `retired`  out  64  count of committed non-nop instructions

## Operation
- Bubble value: stat=AOK, icode=4'h1 (nop), destE=destM=RNONE, valE=valM=0.
- Commit condition per cycle: `!halted && !W_stall && W_stat==AOK`.
- On commit:
  - if `W_destE!=RNONE`: reg[W_destE] <= W_valE
  - if `W_destM!=RNONE`: reg[W_destM] <= W_valM
  - if both equal the same ID, the M write wins (popq %rsp semantics)
  - if `W_icode!=4'h1`: retired <= retired+1, wrapping modulo 2^64
- If `!halted` and `W_stat!=AOK`: no register write, no count; halted <= 1.
- W register update when `!halted`, by priority:
  1. `W_stall` -> hold
  2. `W_bubble` -> load bubble
  3. otherwise -> load m_* inputs
- When halted: W register, register file and counter all hold until reset.
- Reads: `rvalX = (srcX==RNONE) ? 0 : reg[srcX]`, combinational from the array. There is no internal write-to-read bypass; decode forwards from `W_*`.
- `stat` = `W_stat` combinationally.

## Timing
- Reset (synchronous, dominates every other input):
  - W register <= bubble; all 15 registers <= 0
  - halted <= 0; retired <= 0
  - hence stat=AOK, W_icode=1, W_destE=W_destM=F, W_valE=W_valM=0
- Latency:
  - instruction presented on m_* at edge N is in W after edge N
  - its register writes are visible on rvalA/B after edge N+1
  - net: 2 edges from memory-stage output to register-file visibility
- W_stall and W_bubble both high: stall wins.
- Non-AOK instruction in W: it is never committed; halted rises at the next edge; subsequent m_* inputs are ignored.
- Reset while halted clears halted in the same edge; the machine runs normally from the next cycle.
- `srcA==srcB` is legal; both ports return the same value.

## Test plan
- Reset: assert reset 1 cycle with random inputs -> W_icode=1, W_destE=W_destM=F, stat=1, halted=0, retired=0, rvalA for src 0-14 all 0.
- irmovq: m_icode=3, m_stat=1, m_destE=2, m_valE=64'h1234, m_destM=F for 1 cycle, then bubbles -> W_valE=1234 after edge 1; rvalA(src 2)=1234 after edge 2; retired=1.
- popq %rsp: m_icode=B, m_destE=4, m_valE=64'h100, m_destM=4, m_valM=64'hBEEF -> reg4=BEEF after edge 2; retired=1.
- Stall/bubble:
  - W holding destE=3, valE=7 with W_stall=1 and W_bubble=1 for 3 cycles -> W_* unchanged, reg3 not written, retired unchanged.
  - then W_bubble only -> W_icode=1, destE=F.
- Halt: m_stat=2, m_icode=0, then 3 instructions writing reg5 -> halted=1 at the edge after HLT reaches W, stat=2, reg5 unchanged, retired frozen.
- Reset mid-halt: then m_icode=3, destE=1, valE=9 -> halted=0 after reset; rvalA(src 1)=9 two edges later; retired=1.
